// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared defaults and FSM state encoding for the I2S receiver
package i2s_rx_pkg;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_DATA_BITS = 24;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: sck/ws generator; ports clk, rst, run_i in; sck_o, ws_o, bit_cnt_o, rise_o out
module i2s_clkgen import i2s_rx_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  localparam int DW = $clog2(CLK_DIV),
  localparam int BW = $clog2(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_i,
  output logic          sck_o,
  output logic          ws_o,
  output logic [BW-1:0] bit_cnt_o,
  output logic          rise_o
);
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic sck_q, sck_d, ws_q, ws_d, fall;
  always_comb begin
    fall = run_i && div_q == DW'(CLK_DIV - 1);
    rise_o = run_i && div_q == DW'(CLK_DIV / 2 - 1);
    div_d = (!run_i || fall) ? '0 : div_q + 1'b1;
    sck_d = run_i && div_d >= DW'(CLK_DIV / 2);
    bit_d = !run_i ? BW'(SLOT_BITS - 1) :
            !fall ? bit_q :
            bit_q == BW'(SLOT_BITS - 1) ? '0 : bit_q + 1'b1;
    ws_d = !run_i ? 1'b1 : (fall && bit_q == BW'(SLOT_BITS - 1)) ? ~ws_q : ws_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      bit_q <= BW'(SLOT_BITS - 1);
      sck_q <= 1'b0;
      ws_q <= 1'b1;
    end else begin
      div_q <= div_d;
      bit_q <= bit_d;
      sck_q <= sck_d;
      ws_q <= ws_d;
    end
  end
  assign sck_o = sck_q;
  assign ws_o = ws_q;
  assign bit_cnt_o = bit_q;
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S microphone receiver; clk, rst, en, sd_i, ready_i in; sck_o, ws_o, sample_o, chan_o, valid_o, overrun_o out
module i2s_rx import i2s_rx_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 sck_o,
  output logic                 ws_o,
  input  logic                 sd_i,
  output logic [DATA_BITS-1:0] sample_o,
  output logic                 chan_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o
);
  localparam int BW = $clog2(SLOT_BITS);
  logic [0:0] state_q, state_d;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift_q, shift_d, sample_q, sample_d;
  logic rise, cap, load, done_q, done_d, chan_q, chan_d, valid_q, valid_d, ovr_q, ovr_d;
  i2s_clkgen #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == ST_RUN),
    .sck_o    (sck_o),
    .ws_o     (ws_o),
    .bit_cnt_o(bit_cnt),
    .rise_o   (rise)
  );
  always_comb begin
    state_d = en ? ST_RUN : ST_IDLE;
    cap = rise && bit_cnt != '0 && bit_cnt <= BW'(DATA_BITS);
    shift_d = state_q == ST_IDLE ? '0 : cap ? {shift_q[DATA_BITS-2:0], sd_i} : shift_q;
    done_d = rise && bit_cnt == BW'(DATA_BITS);
    load = done_q && (!valid_q || ready_i);
    sample_d = load ? shift_q : sample_q;
    chan_d = load ? ws_o : chan_q;
    valid_d = load || (valid_q && !ready_i);
    ovr_d = (state_q == ST_IDLE && en) ? 1'b0 : ovr_q || (done_q && valid_q && !ready_i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      done_q <= 1'b0;
      sample_q <= '0;
      chan_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      done_q <= done_d;
      sample_q <= sample_d;
      chan_q <= chan_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  assign sample_o = sample_q;
  assign chan_o = chan_q;
  assign valid_o = valid_q;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx with an I2S microphone model
module tb_i2s_rx;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sd_i = 1'b0, ready_i = 1'b0;
  logic sck_o, ws_o, chan_o, valid_o, overrun_o;
  logic [23:0] sample_o, left_w, right_w, w;
  logic [24:0] q[$];
  logic [24:0] e;
  logic mic_slot = 1'b1;
  int mic_pos = 31, pops = 0, n_chk = 0, n_fail = 0;
  longint sck_t = 0, sck_per = 0, ws_t = 0, ws_per = 0;
  i2s_rx #(.CLK_DIV(4), .SLOT_BITS(32), .DATA_BITS(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sck_o    (sck_o),
    .ws_o     (ws_o),
    .sd_i     (sd_i),
    .sample_o (sample_o),
    .chan_o   (chan_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #3;
  endtask
  always @(negedge sck_o) begin
    #1;
    if (en && !rst) begin
      mic_pos = mic_pos == 31 ? 0 : mic_pos + 1;
      if (mic_pos == 0) mic_slot = ~mic_slot;
      chk("ws", ws_o, mic_slot);
      w = mic_slot ? right_w : left_w;
      sd_i = (mic_pos >= 1 && mic_pos <= 24) ? w[24-mic_pos] : 1'($urandom_range(0, 1));
      if (mic_pos == 24) q.push_back({mic_slot, w});
    end
  end
  always @(posedge sck_o) begin
    sck_per = $time - sck_t;
    sck_t = $time;
  end
  always @(ws_o) if (en && !rst) begin
    if (ws_t != 0) ws_per = $time - ws_t;
    ws_t = $time;
  end
  always @(negedge clk) if (!rst && valid_o && ready_i) begin
    chk("sb_avail", q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sample", sample_o, e[23:0]);
      chk("chan", chan_o, e[24]);
    end
    pops++;
  end
  task automatic start(input logic [23:0] l, input logic [23:0] r);
    left_w = l;
    right_w = r;
    mic_pos = 31;
    mic_slot = 1'b1;
    ws_t = 0;
    ws_per = 0;
    en = 1'b1;
  endtask
  task automatic wait_mic(input logic s, input int p);
    for (int i = 0; i < 700; i++) begin
      if (mic_slot == s && mic_pos == p) break;
      tick();
    end
    chk("wait_mic", mic_slot == s && mic_pos == p, 1);
  endtask
  task automatic wait_pops(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (pops >= n) break;
      tick();
    end
    chk("wait_pops", pops >= n, 1);
  endtask
  task automatic wait_hi(input logic sel_ovr);
    for (int i = 0; i < 400; i++) begin
      if (sel_ovr ? overrun_o : valid_o) break;
      tick();
    end
    chk(sel_ovr ? "wait_ovr" : "wait_valid", sel_ovr ? overrun_o : valid_o, 1);
  endtask
  task automatic stop();
    wait_mic(1'b0, 2);
    en = 1'b0;
    repeat (10) tick();
    chk("drained", q.size(), 0);
    chk("idle_valid", valid_o, 0);
  endtask
  initial begin
    left_w = '0;
    right_w = '0;
    repeat (3) tick();
    chk("rst_sck", sck_o, 0);
    chk("rst_ws", ws_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_sample", sample_o, 0);
    chk("rst_chan", chan_o, 0);
    chk("rst_ovr", overrun_o, 0);
    rst = 1'b0;
    tick();
    ready_i = 1'b1;
    start(24'hA5A5A5, 24'h5A5A5A);
    wait_pops(pops + 4);
    chk("sck_period", sck_per, 40);
    chk("ws_half", ws_per, 1280);
    chk("ovr_t1", overrun_o, 0);
    stop();
    start(24'h800000, 24'h7FFFFF);
    wait_pops(pops + 2);
    stop();
    ready_i = 1'b0;
    start(24'h13579B, 24'h2468AC);
    wait_hi(1'b0);
    wait_hi(1'b1);
    chk("ovr_hold_sample", sample_o, 24'h13579B);
    chk("ovr_hold_chan", chan_o, 0);
    chk("ovr_hold_valid", valid_o, 1);
    wait_mic(1'b0, 2);
    en = 1'b0;
    repeat (5) tick();
    chk("ovr_q_size", q.size(), 2);
    if (q.size() > 1) q.delete(1);
    ready_i = 1'b1;
    repeat (3) tick();
    chk("ovr_drain_valid", valid_o, 0);
    chk("ovr_sticky", overrun_o, 1);
    chk("ovr_q_empty", q.size(), 0);
    ready_i = 1'b0;
    start(24'hC0FFEE, 24'h0BEEF0);
    repeat (2) tick();
    chk("ovr_cleared", overrun_o, 0);
    wait_mic(1'b1, 24);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sck_o) break;
    end
    ready_i = 1'b1;
    wait_pops(pops + 2);
    chk("coincide_ovr", overrun_o, 0);
    stop();
    start(24'h111111, 24'h222222);
    wait_mic(1'b0, 10);
    en = 1'b0;
    repeat (10) tick();
    chk("abort_valid", valid_o, 0);
    chk("abort_q", q.size(), 0);
    start(24'h0F1E2D, 24'h3C4B5A);
    wait_pops(pops + 1);
    chk("restart_chan", chan_o, 0);
    stop();
    ready_i = 1'b0;
    start(24'h654321, 24'h123456);
    wait_hi(1'b0);
    repeat (5) tick();
    chk("pre_rst_valid", valid_o, 1);
    rst = 1'b1;
    en = 1'b0;
    tick();
    chk("mrst_sck", sck_o, 0);
    chk("mrst_ws", ws_o, 1);
    chk("mrst_valid", valid_o, 0);
    chk("mrst_sample", sample_o, 0);
    chk("mrst_chan", chan_o, 0);
    chk("mrst_ovr", overrun_o, 0);
    q.delete();
    rst = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
